// File: rtl/video_timing_pkg.sv
// Shared types and the default 640x480 mode for the raster timing generator.
package video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } vtg_state_e;

    localparam int unsigned VTG_H_ACTIVE = 640;
    localparam int unsigned VTG_H_FP     = 16;
    localparam int unsigned VTG_H_SYNC   = 96;
    localparam int unsigned VTG_H_BP     = 48;
    localparam int unsigned VTG_V_ACTIVE = 480;
    localparam int unsigned VTG_V_FP     = 10;
    localparam int unsigned VTG_V_SYNC   = 2;
    localparam int unsigned VTG_V_BP     = 33;
    localparam int unsigned VTG_CW       = 10;
    localparam int unsigned VTG_FC_W     = 8;
    localparam bit          VTG_H_POL    = 1'b0;
    localparam bit          VTG_V_POL    = 1'b0;

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: CW-bit counter with enable, synchronous clear, wrap at TOTAL-1 and carry-out.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned CW    = VTG_CW,
    parameter int unsigned TOTAL = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt_c,
    output logic          carry_c
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    always_comb begin
        count_nxt_c = count;
        carry_c     = 1'b0;
        if (clr) begin
            count_nxt_c = '0;
        end else if (en) begin
            if (count == LAST) begin
                count_nxt_c = '0;
                carry_c     = 1'b1;
            end else begin
                count_nxt_c = count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt_c;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with run/stop control and line/frame strobes.
// Optional completed-frame counter port enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VTG_H_ACTIVE,
    parameter int unsigned H_FP       = VTG_H_FP,
    parameter int unsigned H_SYNC     = VTG_H_SYNC,
    parameter int unsigned H_BP       = VTG_H_BP,
    parameter int unsigned V_ACTIVE   = VTG_V_ACTIVE,
    parameter int unsigned V_FP       = VTG_V_FP,
    parameter int unsigned V_SYNC     = VTG_V_SYNC,
    parameter int unsigned V_BP       = VTG_V_BP,
    parameter bit          H_SYNC_POL = VTG_H_POL,
    parameter bit          V_SYNC_POL = VTG_V_POL,
    parameter int unsigned CW         = VTG_CW,
    parameter int unsigned FC_W       = VTG_FC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_en,
    input  logic            run,
    output logic            hsync,
    output logic            vsync,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            de,
    output logic            line_start,
    output logic            frame_start,
`ifdef VTG_FRAME_COUNT_EN
    output logic [FC_W-1:0] frame_cnt,
`endif
    output logic            busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (((64'(1) << CW) < 64'(H_TOTAL)) || ((64'(1) << CW) < 64'(V_TOTAL)) ||
        (H_SYNC == 0) || (V_SYNC == 0) || (FC_W == 0)) begin : g_param_err
        $fatal(1, "video_timing_gen: invalid timing parameters");
    end

    vtg_state_e      state_q, state_d;
    logic [CW-1:0]   x_nxt_c, y_nxt_c;
    logic            x_carry_c, y_carry_c;
    logic            advance_c, idle_c, active_d;
    logic            de_d, hsync_d, vsync_d, line_start_d, frame_start_d;

    assign idle_c    = (state_q == IDLE);
    assign advance_c = pix_en && !idle_c;

    vtg_axis_counter #(.CW(CW), .TOTAL(H_TOTAL)) u_x_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (idle_c),
        .en          (advance_c),
        .count       (x),
        .count_nxt_c (x_nxt_c),
        .carry_c     (x_carry_c)
    );

    vtg_axis_counter #(.CW(CW), .TOTAL(V_TOTAL)) u_y_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (idle_c),
        .en          (x_carry_c),
        .count       (y),
        .count_nxt_c (y_nxt_c),
        .carry_c     (y_carry_c)
    );

    // y carry only fires while leaving the last pixel of the frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (run && pix_en) state_d = RUN;
            RUN:      if (!run) state_d = y_carry_c ? IDLE : STOPPING;
            STOPPING: begin
                if (run)            state_d = RUN;
                else if (y_carry_c) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Decode from the next position so all registered outputs move together
    always_comb begin
        active_d      = (state_d != IDLE);
        de_d          = active_d && (x_nxt_c < H_ACT) && (y_nxt_c < V_ACT);
        hsync_d       = (active_d && (x_nxt_c >= HS_BEG) && (x_nxt_c < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = (active_d && (y_nxt_c >= VS_BEG) && (y_nxt_c < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        line_start_d  = pix_en && active_d && (x_nxt_c == '0);
        frame_start_d = line_start_d && (y_nxt_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy        <= active_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
            if (pix_en) begin
                de    <= de_d;
                hsync <= hsync_d;
                vsync <= vsync_d;
            end
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         frame_cnt <= '0;
        else if (y_carry_c) frame_cnt <= frame_cnt + FC_W'(1);
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized self-checking bench for video_timing_gen against a linear-pixel-index reference model.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n, pix_en, run;
    logic       hsync, vsync, de, line_start, frame_start, busy;
    logic [3:0] x, y;
`ifdef VTG_FRAME_COUNT_EN
    logic [7:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: generating flag, linear pixel index in frame, strobes, completed frames
    bit m_active, m_ls, m_fs;
    int m_pos, m_fc;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(4), .FC_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .run         (run),
        .hsync       (hsync),
        .vsync       (vsync),
        .x           (x),
        .y           (y),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start),
`ifdef VTG_FRAME_COUNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0; m_pos = 0; m_ls = 1'b0; m_fs = 1'b0; m_fc = 0;
    endfunction

    function automatic void model_step(input bit r, input bit p);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (p) begin
            if (!m_active) begin
                if (r) begin
                    m_active = 1'b1; m_pos = 0; m_ls = 1'b1; m_fs = 1'b1;
                end
            end else if (m_pos == FR - 1) begin
                m_fc++;
                m_pos = 0;
                if (r) begin
                    m_ls = 1'b1; m_fs = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_pos++;
                m_ls = (m_pos % HT == 0);
            end
        end
    endfunction

    task automatic check_outputs();
        int ex, ey;
        ex = m_pos % HT;
        ey = m_pos / HT;
        check("x", int'(x), ex);
        check("y", int'(y), ey);
        check("de", int'(de), int'(m_active && ex < HA && ey < VA));
        check("hsync", int'(hsync), int'(!(m_active && ex >= HA + HF && ex < HA + HF + HS)));
        check("vsync", int'(vsync), int'(!(m_active && ey >= VA + VF && ey < VA + VF + VS)));
        check("line_start", int'(line_start), int'(m_ls));
        check("frame_start", int'(frame_start), int'(m_fs));
        check("busy", int'(busy), int'(m_active));
`ifdef VTG_FRAME_COUNT_EN
        check("frame_cnt", int'(frame_cnt), m_fc % 256);
`endif
    endtask

    // Called at a negedge: drive, take the posedge, compare at the next negedge
    task automatic tick(input bit r, input bit p);
        run    = r;
        pix_en = p;
        @(posedge clk);
        model_step(r, p);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic goto_pos(input int target);
        for (int i = 0; i < 2 * FR + 4; i++) begin
            if (m_active && m_pos == target) break;
            tick(1'b1, 1'b1);
        end
        check("goto_x", int'(x), target % HT);
        check("goto_y", int'(y), target / HT);
    endtask

    initial begin
        int last_fs, de_cnt, prev_x, prev_y, idle_seen;
        bit r;

        rst_n = 1'b0; run = 1'b0; pix_en = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);

        // Continuous run: first pixel, de count per frame, frame_start period
        tick(1'b1, 1'b1);
        check("first_x", int'(x), 0);
        check("first_de", int'(de), 1);
        check("first_fs", int'(frame_start), 1);
        last_fs = 0;
        de_cnt  = 1;
        for (int i = 1; i <= 2 * FR + 4; i++) begin
            tick(1'b1, 1'b1);
            if (frame_start) begin
                check("fs_period", i - last_fs, FR);
                check("de_per_frame", de_cnt, HA * VA);
                last_fs = i;
                de_cnt  = 0;
            end
            if (de) de_cnt++;
        end

        // pix_en toggling
        for (int i = 0; i < 40; i++) tick(1'b1, i[0] == 1'b0);

        // Drop run at (3,2): frame completes then idles
        goto_pos(2 * HT + 3);
        prev_x = 0; prev_y = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            prev_x = int'(x);
            prev_y = int'(y);
            tick(1'b0, 1'b1);
            if (!busy) break;
        end
        check("stop_last_x", prev_x, HT - 1);
        check("stop_last_y", prev_y, VT - 1);
        check("stop_busy", int'(busy), 0);
        check("stop_de", int'(de), 0);
        check("stop_hsync", int'(hsync), 1);
        check("stop_vsync", int'(vsync), 1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);

        // Drop at (3,2), restore at (5,4): no idle entry
        goto_pos(2 * HT + 3);
        idle_seen = 0;
        for (int i = 0; i < FR && !(m_pos == 4 * HT + 5); i++) begin
            tick(1'b0, 1'b1);
            if (!busy) idle_seen++;
        end
        for (int i = 0; i < FR + 10; i++) begin
            tick(1'b1, 1'b1);
            if (!busy) idle_seen++;
        end
        check("restore_no_idle", idle_seen, 0);

        // Randomized run/pix_en
        r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) r = ~r;
            tick(r, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-frame at (9,3)
        goto_pos(3 * HT + 9);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Two full frames from reset
        for (int i = 0; i < 2 * FR + 1; i++) tick(1'b1, 1'b1);
`ifdef VTG_FRAME_COUNT_EN
        check("frame_cnt_two", int'(frame_cnt), 2);
`endif
        check("two_frames_x", int'(x), 0);
        check("two_frames_y", int'(y), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
